mul4_seq: RTL and testbench

- Sequential shift-add unsigned multiplier that sits directly downstream of the 4-bit ALU datapath.
- Takes two 4-bit operands and produces an 8-bit product over WIDTH iterations, one partial-product add per clock.
- Per-iteration add/shift is built from the team's 2-input gate primitives and 4-bit bitwise blocks, plus a WIDTH-bit ripple adder.
- Start/done handshake lets the ALU control sequencer launch a multiply and wait for the result.

---
 rtl/mul4_seq.sv | 142 ++++++++++++++
 tb/tb_mul4_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul4_seq.sv
// rtl/mul4_seq.sv - sequential shift-add unsigned multiplier with start/done handshake

// WIDTH-bit ripple-carry adder built from 2-input gates, carry-in tied low.
module mul4_seq_ripple_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] c;
  logic [WIDTH-1:0] hx;

  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign hx[i]  = x[i] ^ y[i];
      assign s[i]   = hx[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & hx[i]);
    end
  endgenerate

  assign co = c[WIDTH];

endmodule

// Multiplier top: one partial-product add and right shift per clock.
module mul4_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt;
  logic               last_iter;
  logic               accept;

  // Partial product is the multiplicand gated by the current multiplier bit.
  assign addend = mcand & {WIDTH{acc[0]}};

  mul4_seq_ripple_add #(.WIDTH(WIDTH)) u_add (
    .x  (acc[2*WIDTH-1:WIDTH]),
    .y  (addend),
    .s  (sum),
    .co (carry)
  );

  // Carry-out becomes the new MSB so no bit of the sum is dropped by the shift.
  assign acc_step  = {carry, sum, acc[WIDTH-1:1]};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; busy and done decode disjoint states.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_BUSY;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath, and product update on the final iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == S_BUSY) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (last_iter) begin
        product <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_mul4_seq.sv
// tb/tb_mul4_seq.sv - directed self-checking bench for mul4_seq

module tb_mul4_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_vec  = 0;
  int n_miss = 0;

  mul4_seq #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply and observe 12 cycles; stimulus and measurement only.
  task automatic do_mul(input logic [3:0] ta, input logic [3:0] tb, output logic [7:0] p,
                        output int nbusy, output int ndone, output int overlap);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; overlap = 0; p = 8'hxx;
    for (int i = 0; i < 12; i++) begin
      if (busy) nbusy++;
      if (done) begin ndone++; p = product; end
      if (busy && done) overlap++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
    #3;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (product !== 8'h00) begin n_miss++; $display("FAIL reset_product got=%h exp=00", product); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] p; int nb, nd, ov;
    do_mul(4'h3, 4'h5, p, nb, nd, ov);
    n_vec++; if (p !== 8'h0F) begin n_miss++; $display("FAIL basic_product got=%h exp=0f", p); end
    n_vec++; if (nb != 4) begin n_miss++; $display("FAIL basic_busy_cycles got=%0d exp=4", nb); end
    n_vec++; if (nd != 1) begin n_miss++; $display("FAIL basic_done_cycles got=%0d exp=1", nd); end
    repeat (10) @(negedge clk);
    n_vec++; if (product !== 8'h0F) begin n_miss++; $display("FAIL basic_hold got=%h exp=0f", product); end
  endtask

  task automatic test_corners();
    logic [3:0] va [4] = '{4'hF, 4'h0, 4'h9, 4'h1};
    logic [3:0] vb [4] = '{4'hF, 4'h9, 4'h0, 4'hA};
    logic [7:0] ve [4] = '{8'hE1, 8'h00, 8'h00, 8'h0A};
    logic [7:0] p; int nb, nd, ov;
    for (int i = 0; i < 4; i++) begin
      do_mul(va[i], vb[i], p, nb, nd, ov);
      n_vec++;
      if (p !== ve[i]) begin
        n_miss++; $display("FAIL corner_%0d a=%h b=%h got=%h exp=%h", i, va[i], vb[i], p, ve[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int nb = 0, nd = 0;
    logic [7:0] p = 8'hxx;
    @(negedge clk);
    start = 1'b1; a = 4'h2; b = 4'h7;
    @(negedge clk);
    start = 1'b0;
    if (busy) nb++;
    @(negedge clk);
    if (busy) nb++;
    start = 1'b1; a = 4'hF; b = 4'hF;
    @(negedge clk);
    start = 1'b0; a = 4'h0; b = 4'h0;
    for (int i = 0; i < 10 && nd == 0; i++) begin
      if (busy) nb++;
      if (done) begin nd++; p = product; end
      @(negedge clk);
    end
    n_vec++; if (nd != 1) begin n_miss++; $display("FAIL busy_start_done_seen got=%0d exp=1", nd); end
    n_vec++; if (p !== 8'h0E) begin n_miss++; $display("FAIL busy_start_product got=%h exp=0e", p); end
    n_vec++; if (nb != 4) begin n_miss++; $display("FAIL busy_start_busy_cycles got=%0d exp=4", nb); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, idle_gap = 0;
    logic [7:0] p1 = 8'hxx, p2 = 8'hxx;
    @(negedge clk);
    start = 1'b1; a = 4'h6; b = 4'h7;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      if (!busy && !done) idle_gap++;
      if (done && d1 < 0) begin
        d1 = k; p1 = product; a = 4'hC; b = 4'h3;
      end else if (done && d2 < 0) begin
        d2 = k; p2 = product; start = 1'b0;
      end
      @(negedge clk);
      if (d2 >= 0) break;
    end
    start = 1'b0;
    n_vec++; if (p1 !== 8'h2A) begin n_miss++; $display("FAIL b2b_first got=%h exp=2a", p1); end
    n_vec++; if (p2 !== 8'h24) begin n_miss++; $display("FAIL b2b_second got=%h exp=24", p2); end
    n_vec++; if (d1 != 4) begin n_miss++; $display("FAIL b2b_first_done_cycle got=%0d exp=4", d1); end
    n_vec++; if (d2 != 9) begin n_miss++; $display("FAIL b2b_second_done_cycle got=%0d exp=9", d2); end
    n_vec++; if (idle_gap != 0) begin n_miss++; $display("FAIL b2b_idle_cycles got=%0d exp=0", idle_gap); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [7:0] p; int nb, nd, ov;
    int late_done = 0;
    @(negedge clk);
    start = 1'b1; a = 4'hF; b = 4'hF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL areset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL areset_done got=%b exp=0", done); end
    n_vec++; if (product !== 8'h00) begin n_miss++; $display("FAIL areset_product got=%h exp=00", product); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) late_done++;
      @(negedge clk);
    end
    n_vec++; if (late_done != 0) begin n_miss++; $display("FAIL areset_no_resume got=%0d exp=0", late_done); end
    do_mul(4'h2, 4'h3, p, nb, nd, ov);
    n_vec++; if (p !== 8'h06) begin n_miss++; $display("FAIL areset_next_product got=%h exp=06", p); end
  endtask

  task automatic test_sweep();
    logic [7:0] p, exp_p; int nb, nd, ov;
    int bad_p = 0, bad_b = 0, bad_d = 0, bad_o = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp_p = 8'(i * j);
        do_mul(4'(i), 4'(j), p, nb, nd, ov);
        n_vec++;
        if (p !== exp_p || nb != 4 || nd != 1 || ov != 0) begin
          n_miss++;
          $display("FAIL sweep a=%0d b=%0d product got=%h exp=%h busy got=%0d exp=4 done got=%0d exp=1 overlap got=%0d exp=0",
                   i, j, p, exp_p, nb, nd, ov);
          if (p !== exp_p) bad_p++;
          if (nb != 4) bad_b++;
          if (nd != 1) bad_d++;
          if (ov != 0) bad_o++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_busy_start();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
